// File: rtl/rs_station_param.sv
// rtl/rs_station_param.sv - parameterised reservation station with CDB wakeup/bypass and in-order-by-index issue
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global enable; low freezes every register
//   flush                     rollback: drops all waiting entries and the pending issue
//   inst_ID_*                 insert request (operands, tags, immediate, pc, opcode, class)
//   cdb_flag/cdb_rob_id/cdb_val  NCDB packed broadcast ports (port k at slice k)
//   RS_nex_ava, free_cnt      occupancy status (combinational)
//   exe_RS_*                  registered issue to the execution unit
`ifndef BRC
`define BRC 3'd4
`endif

module rs_station_param #(
   parameter int DEPTH = 16,
   parameter int IDXBW = 4,
   parameter int ROBBW = 4,
   parameter int NCDB  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  inst_ID_flag,
   input  logic [31:0]           inst_ID_V1,
   input  logic [31:0]           inst_ID_V2,
   input  logic [31:0]           inst_ID_A,
   input  logic [31:0]           inst_ID_pc,
   input  logic [ROBBW-1:0]      inst_ID_Q1,
   input  logic [ROBBW-1:0]      inst_ID_Q2,
   input  logic [ROBBW-1:0]      inst_ID_rob_id,
   input  logic [5:0]            inst_ID_code,
   input  logic [2:0]            inst_ID_type,
   input  logic [NCDB-1:0]       cdb_flag,
   input  logic [NCDB*ROBBW-1:0] cdb_rob_id,
   input  logic [NCDB*32-1:0]    cdb_val,
   output logic                  RS_nex_ava,
   output logic [IDXBW:0]        free_cnt,
   output logic                  exe_RS_flag,
   output logic [31:0]           exe_RS_V1,
   output logic [31:0]           exe_RS_V2,
   output logic [31:0]           exe_RS_A,
   output logic [31:0]           exe_RS_pc,
   output logic [5:0]            exe_RS_code,
   output logic [ROBBW-1:0]      exe_RS_rob_id
);

   logic [DEPTH-1:0] busy;
   logic [ROBBW-1:0] q1   [DEPTH];
   logic [ROBBW-1:0] q2   [DEPTH];
   logic [31:0]      v1   [DEPTH];
   logic [31:0]      v2   [DEPTH];
   logic [31:0]      imm  [DEPTH];
   logic [31:0]      pc   [DEPTH];
   logic [5:0]       code [DEPTH];
   logic [ROBBW-1:0] rob  [DEPTH];

   logic [DEPTH-1:0] ready;
   logic             any_ready;
   logic [IDXBW-1:0] iss_idx;
   logic [IDXBW-1:0] free_idx;
   logic             ins_ok;
   logic [31:0]      ins_v1, ins_v2;
   logic [ROBBW-1:0] ins_q1, ins_q2;

   // Readiness, lowest-index pickers and the free count all look only at
   // registered state, so a just-woken or just-inserted entry waits a cycle.
   always_comb begin
      ready     = '0;
      any_ready = 1'b0;
      iss_idx   = '0;
      free_idx  = '0;
      free_cnt  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready[i] = busy[i] && (q1[i] == '0) && (q2[i] == '0);
         if (ready[i]) begin
            any_ready = 1'b1;
            iss_idx   = i[IDXBW-1:0];
         end
         if (!busy[i]) begin
            free_idx = i[IDXBW-1:0];
            free_cnt = free_cnt + (IDXBW+1)'(1);
         end
      end
   end

   // Insert-time bypass; scanning from the top port down lets port 0 win.
   always_comb begin
      ins_v1 = inst_ID_V1;
      ins_v2 = inst_ID_V2;
      ins_q1 = inst_ID_Q1;
      ins_q2 = inst_ID_Q2;
      for (int k = NCDB - 1; k >= 0; k--) begin
         if (cdb_flag[k] && inst_ID_Q1 != '0 && cdb_rob_id[k*ROBBW +: ROBBW] == inst_ID_Q1) begin
            ins_v1 = cdb_val[k*32 +: 32];
            ins_q1 = '0;
         end
         if (cdb_flag[k] && inst_ID_Q2 != '0 && cdb_rob_id[k*ROBBW +: ROBBW] == inst_ID_Q2) begin
            ins_v2 = cdb_val[k*32 +: 32];
            ins_q2 = '0;
         end
      end
   end

   assign ins_ok = rdy && !flush && inst_ID_flag && (inst_ID_type <= `BRC) && (free_cnt != '0);

   assign RS_nex_ava = any_ready || (free_cnt >= (IDXBW+1)'(2)) ||
                       ((free_cnt == (IDXBW+1)'(1)) && !inst_ID_flag);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q1[i] <= '0;
            q2[i] <= '0;
         end
         exe_RS_flag   <= 1'b0;
         exe_RS_V1     <= '0;
         exe_RS_V2     <= '0;
         exe_RS_A      <= '0;
         exe_RS_pc     <= '0;
         exe_RS_code   <= '0;
         exe_RS_rob_id <= '0;
      end else if (rdy) begin
         if (flush) begin
            busy        <= '0;
            exe_RS_flag <= 1'b0;
         end else begin
            // Wakeup: later (lower-k) assignments override, giving port 0 priority.
            for (int i = 0; i < DEPTH; i++) begin
               for (int k = NCDB - 1; k >= 0; k--) begin
                  if (busy[i] && cdb_flag[k] && q1[i] != '0 && cdb_rob_id[k*ROBBW +: ROBBW] == q1[i]) begin
                     v1[i] <= cdb_val[k*32 +: 32];
                     q1[i] <= '0;
                  end
                  if (busy[i] && cdb_flag[k] && q2[i] != '0 && cdb_rob_id[k*ROBBW +: ROBBW] == q2[i]) begin
                     v2[i] <= cdb_val[k*32 +: 32];
                     q2[i] <= '0;
                  end
               end
            end

            if (any_ready) begin
               exe_RS_flag   <= 1'b1;
               exe_RS_V1     <= v1[iss_idx];
               exe_RS_V2     <= v2[iss_idx];
               exe_RS_A      <= imm[iss_idx];
               exe_RS_pc     <= pc[iss_idx];
               exe_RS_code   <= code[iss_idx];
               exe_RS_rob_id <= rob[iss_idx];
               busy[iss_idx] <= 1'b0;
            end else begin
               exe_RS_flag <= 1'b0;
            end

            // The free slot is never busy, so it cannot collide with the issue slot.
            if (ins_ok) begin
               busy[free_idx] <= 1'b1;
               v1[free_idx]   <= ins_v1;
               v2[free_idx]   <= ins_v2;
               q1[free_idx]   <= ins_q1;
               q2[free_idx]   <= ins_q2;
               imm[free_idx]  <= inst_ID_A;
               pc[free_idx]   <= inst_ID_pc;
               code[free_idx] <= inst_ID_code;
               rob[free_idx]  <= inst_ID_rob_id;
            end
         end
      end
   end

endmodule
